// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the asynchronous instruction memory,
// and produces the IF/ID register with stall/flush/redirect, early JAL and halt detection.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          IMEM_AW   = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               reset,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc,
  output logic [31:0]        if_id_pc,
  output logic [31:0]        if_id_pc4,
  output logic [31:0]        if_id_instr,
  output logic               if_id_valid,
  output logic               if_id_pred_taken,
  output logic               halted,
  output logic               misalign_err
);

  typedef enum logic {RUN, HALT} state_t;

  localparam logic [31:0] HALT_INSTR = 32'h0000_006f;
  localparam logic [6:0]  OP_JAL     = 7'b1101111;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] id_pc_n, id_pc4_n, id_instr_n;
  logic        id_valid_n, id_pred_n, misalign_n;
  logic [31:0] jimm, pc_plus4;
  logic        is_jal;

  assign imem_addr = pc[IMEM_AW+1:2];
  assign halted    = (state == HALT);
  assign pc_plus4  = pc + 32'd4;
  assign is_jal    = (imem_rdata[6:0] == OP_JAL);
  assign jimm      = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                      imem_rdata[20], imem_rdata[30:21], 1'b0};

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    id_pc_n    = if_id_pc;
    id_pc4_n   = if_id_pc4;
    id_instr_n = if_id_instr;
    id_valid_n = if_id_valid;
    id_pred_n  = if_id_pred_taken;
    misalign_n = misalign_err;

    if (redirect_valid) begin
      // Redirect wins over stall in both states and always resumes fetching.
      pc_n       = {redirect_pc[31:2], 2'b00};
      id_instr_n = NOP_INSTR;
      id_valid_n = 1'b0;
      id_pred_n  = 1'b0;
      state_n    = RUN;
      if (redirect_pc[1:0] != 2'b00) misalign_n = 1'b1;
    end else if (state == HALT) begin
      if (!stall) begin
        id_instr_n = NOP_INSTR;
        id_valid_n = 1'b0;
        id_pred_n  = 1'b0;
      end
    end else if (flush) begin
      pc_n       = pc_plus4;
      id_instr_n = NOP_INSTR;
      id_valid_n = 1'b0;
      id_pred_n  = 1'b0;
    end else if (!stall) begin
      id_pc_n    = pc;
      id_pc4_n   = pc_plus4;
      id_instr_n = imem_rdata;
      id_valid_n = 1'b1;
      if (is_jal) begin
        pc_n      = pc + jimm;
        id_pred_n = 1'b1;
        if (imem_rdata == HALT_INSTR) state_n = HALT;
      end else begin
        pc_n      = pc_plus4;
        id_pred_n = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= RUN;
      pc               <= {RESET_PC[31:2], 2'b00};
      if_id_pc         <= '0;
      if_id_pc4        <= 32'd4;
      if_id_instr      <= NOP_INSTR;
      if_id_valid      <= 1'b0;
      if_id_pred_taken <= 1'b0;
      misalign_err     <= 1'b0;
    end else begin
      state            <= state_n;
      pc               <= pc_n;
      if_id_pc         <= id_pc_n;
      if_id_pc4        <= id_pc4_n;
      if_id_instr      <= id_instr_n;
      if_id_valid      <= id_valid_n;
      if_id_pred_taken <= id_pred_n;
      misalign_err     <= misalign_n;
    end
  end

endmodule
